// File: rtl/video_timing_pattern_gen.sv
// Programmable raster timing generator (vsync/hsync/valid) with a test-pattern pixel stream.
// Frames always run to completion once started; enable only decides whether another frame follows.
module video_timing_pattern_gen #(
  parameter int unsigned DW       = 8,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BACK   = 220,
  parameter int unsigned H_DISP   = 1280,
  parameter int unsigned H_FRONT  = 110,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BACK   = 20,
  parameter int unsigned V_DISP   = 720,
  parameter int unsigned V_FRONT  = 5,
  parameter int unsigned CHK_LOG2 = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] const_val,
  output logic          post_img_vsync,
  output logic          post_img_hsync,
  output logic          post_img_valid,
  output logic [DW-1:0] post_img_data,
  output logic [15:0]   frame_cnt,
  output logic          busy
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int unsigned H_ACT0  = H_SYNC + H_BACK;
  localparam int unsigned H_ACT1  = H_ACT0 + H_DISP;
  localparam int unsigned V_ACT0  = V_SYNC + V_BACK;
  localparam int unsigned V_ACT1  = V_ACT0 + V_DISP;
  localparam int unsigned CW      = (DW > CHK_LOG2 + 1) ? DW : CHK_LOG2 + 1;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [1:0]    mode_q, mode_d;
  logic [DW-1:0] cval_q, cval_d;
  logic          vsync_q, vsync_d;
  logic          hsync_q, hsync_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [15:0]   frame_q, frame_d;

  logic          active, last_pix, frame_start, in_act;
  logic [CW-1:0] x_w, y_w;
  logic [DW-1:0] pix;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    mode_d  = mode_q;
    cval_d  = cval_q;
    frame_d = frame_q;
    pix     = '0;

    active      = (state_q != IDLE);
    last_pix    = (h_q == H_LAST) && (v_q == V_LAST);
    frame_start = (h_q == '0) && (v_q == '0);

    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (last_pix) state_d = enable ? RUN : IDLE;
               else if (!enable) state_d = DRAIN;
      DRAIN:   if (last_pix) state_d = IDLE;
               else if (enable) state_d = RUN;
      default: state_d = IDLE;
    endcase

    if (active) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end else begin
      h_d = '0;
      v_d = '0;
    end

    // Pattern controls are sampled only at the frame origin so a frame is never mixed.
    if (active && frame_start) begin
      mode_d = mode;
      cval_d = const_val;
    end

    if (active && last_pix) frame_d = frame_q + 16'd1;

    x_w    = CW'(32'(h_q) - H_ACT0);
    y_w    = CW'(32'(v_q) - V_ACT0);
    in_act = (32'(h_q) >= H_ACT0) && (32'(h_q) < H_ACT1) &&
             (32'(v_q) >= V_ACT0) && (32'(v_q) < V_ACT1);

    unique case (mode_q)
      2'd0:    pix = x_w[DW-1:0];
      2'd1:    pix = y_w[DW-1:0];
      2'd2:    pix = (x_w[CHK_LOG2] ^ y_w[CHK_LOG2]) ? '1 : '0;
      default: pix = cval_q;
    endcase

    vsync_d = active && (32'(v_q) < V_SYNC);
    hsync_d = active && (32'(h_q) < H_SYNC);
    valid_d = active && in_act;
    data_d  = valid_d ? pix : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
      mode_q  <= '0;
      cval_q  <= '0;
      vsync_q <= 1'b0;
      hsync_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      mode_q  <= mode_d;
      cval_q  <= cval_d;
      vsync_q <= vsync_d;
      hsync_q <= hsync_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      frame_q <= frame_d;
    end
  end

  assign post_img_vsync = vsync_q;
  assign post_img_hsync = hsync_q;
  assign post_img_valid = valid_q;
  assign post_img_data  = data_q;
  assign frame_cnt      = frame_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Directed bench for video_timing_pattern_gen on a small 14x7 raster (8x4 active).
module tb_video_timing_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  const_val = 8'd0;
  logic        vsync, hsync, valid, busy;
  logic [7:0]  data;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  video_timing_pattern_gen #(
    .DW(8), .H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1), .CHK_LOG2(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .const_val(const_val),
    .post_img_vsync(vsync), .post_img_hsync(hsync), .post_img_valid(valid),
    .post_img_data(data), .frame_cnt(frame_cnt), .busy(busy)
  );

  // Active line y holds pixel x in byte x counted from the MSB end.
  typedef struct {
    logic [1:0]       mode;
    logic [7:0]       cval;
    logic [3:0][63:0] lines;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic do_reset(input vec_t v);
    rst_n = 1'b0;
    enable = 1'b1;
    mode = v.mode;
    const_val = v.cval;
    #1;
    chk("reset_outputs", {20'd0, busy, vsync, hsync, valid, data}, 32'd0);
    chk("reset_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("start_cycle", {20'd0, busy, vsync, hsync, valid, data}, 32'h800);
  endtask

  // Checks the 98 output cycles of one frame; next posedge must show pixel 0.
  task automatic check_frame(input vec_t v, input logic busy_end, input int chg_k,
                             input logic [7:0] chg_val, input int drop_k);
    int nvalid = 0;
    for (int k = 0; k < 98; k++) begin
      int h, vl;
      logic ev, eb;
      logic [7:0] ed;
      logic [63:0] lv;
      @(posedge clk); #1;
      h  = k % 14;
      vl = k / 14;
      ev = (h >= 4) && (h < 12) && (vl >= 2) && (vl < 6);
      ed = 8'd0;
      if (ev) begin
        lv = v.lines[vl-2];
        ed = lv[63 - 8*(h-4) -: 8];
      end
      eb = (k == 97) ? busy_end : 1'b1;
      chk($sformatf("pixel_k%0d", k), {20'd0, busy, vsync, hsync, valid, data},
          {20'd0, eb, (vl < 1), (h < 2), ev, ed});
      if (valid) nvalid++;
      if (k == chg_k) const_val = chg_val;
      if (k == drop_k) enable = 1'b0;
    end
    chk("valid_count", nvalid, 32);
  endtask

  initial begin
    tbl[0] = '{2'd0, 8'h00, {64'h0001020304050607, 64'h0001020304050607,
                             64'h0001020304050607, 64'h0001020304050607}};
    tbl[1] = '{2'd1, 8'h00, {64'h0303030303030303, 64'h0202020202020202,
                             64'h0101010101010101, 64'h0000000000000000}};
    tbl[2] = '{2'd2, 8'h00, {64'hFFFF0000FFFF0000, 64'hFFFF0000FFFF0000,
                             64'h0000FFFF0000FFFF, 64'h0000FFFF0000FFFF}};
    tbl[3] = '{2'd3, 8'h5A, {64'h5A5A5A5A5A5A5A5A, 64'h5A5A5A5A5A5A5A5A,
                             64'h5A5A5A5A5A5A5A5A, 64'h5A5A5A5A5A5A5A5A}};
    tbl[4] = '{2'd3, 8'h11, {64'h1111111111111111, 64'h1111111111111111,
                             64'h1111111111111111, 64'h1111111111111111}};

    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      do_reset(tbl[i]);
      check_frame(tbl[i], 1'b1, -1, 8'h00, -1);
      chk($sformatf("frame_cnt_vec%0d", i), {16'd0, frame_cnt}, 32'd1);
    end

    // Mid-frame const_val change is held off until the next frame.
    do_reset(tbl[3]);
    check_frame(tbl[3], 1'b1, 50, 8'h11, -1);
    chk("frame_cnt_const1", {16'd0, frame_cnt}, 32'd1);
    check_frame(tbl[4], 1'b1, -1, 8'h00, -1);
    chk("frame_cnt_const2", {16'd0, frame_cnt}, 32'd2);

    // Dropping enable mid-frame drains the frame, then goes idle.
    do_reset(tbl[0]);
    check_frame(tbl[0], 1'b0, -1, 8'h00, 40);
    chk("frame_cnt_drain", {16'd0, frame_cnt}, 32'd1);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("idle_outputs", {busy, vsync, hsync, valid, data, frame_cnt}, {12'd0, 16'd1});
    end

    // Asynchronous reset in the middle of the second frame.
    do_reset(tbl[0]);
    check_frame(tbl[0], 1'b1, -1, 8'h00, -1);
    repeat (29) @(posedge clk);
    #1;
    chk("pre_reset_hsync", {31'd0, hsync}, 32'd1);
    chk("pre_reset_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {busy, vsync, hsync, valid, data, frame_cnt}, 28'd0);
    do_reset(tbl[0]);
    check_frame(tbl[0], 1'b1, -1, 8'h00, -1);
    chk("frame_cnt_after_reset", {16'd0, frame_cnt}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
